fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Packet-level round-robin arbiter that shares the single write port of the synchronous FIFO (fifo_write_req / fifo_write_data / fifo_full) among NUM_REQ independent producers. A grant is held for a whole packet (delimited by per-requester last flags) so beats from different producers never interleave in the FIFO. A beat-limit guard stops a runaway producer from starving the others. The block sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
- WIDTH, 8, data width; equals the FIFO WIDTH
- NUM_REQ, 4, number of producers (2..16)
- MAX_BEATS, 16, maximum beats per grant before forced release (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  producer i has a beat on its data slice
- req_last  in  NUM_REQ  beat from producer i is its packet's final beat
- req_data  in  NUM_REQ*WIDTH  producer i data at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  beat of producer i accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_write_req  out  1  write strobe to FIFO
- fifo_write_data  out  WIDTH  write data to FIFO
- grant  out  NUM_REQ  one-hot current owner, 0 when IDLE
- err_overrun  out  1  one-cycle pulse when a grant is force-released at MAX_BEATS

## Operation
- States: IDLE, BUSY. Registers: state, owner (clog2(NUM_REQ) bits), rr_ptr (same width), beat_cnt (clog2(MAX_BEATS+1) bits), err_overrun.
- IDLE: if any req_valid, winner = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ; next cycle owner=winner, state=BUSY, beat_cnt=0. No transfer occurs in IDLE. If no req_valid, stay IDLE.
- BUSY (combinational outputs): req_ready[owner] = !fifo_full; all other req_ready = 0; fifo_write_req = req_valid[owner] & !fifo_full; fifo_write_data = req_data slice of owner (driven regardless of strobe).
- Beat accepted (fifo_write_req=1): beat_cnt+1.
  - If req_last[owner]: state=IDLE, rr_ptr=owner+1 mod NUM_REQ, beat_cnt=0.
  - Else if beat_cnt+1 == MAX_BEATS: forced release as above plus err_overrun=1 for one cycle; producer's remaining beats compete again as a new packet.
- BUSY with owner not valid or fifo_full: hold all state; grant is never dropped mid-packet for idleness.
- grant = one-hot(owner) in BUSY, 0 in IDLE.
- Requesters deasserting req_valid while not granted: legal, no effect. req_last ignored unless valid&ready.

## Timing
- Reset (asynchronous, any state): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, err_overrun=0; hence req_ready=0, fifo_write_req=0, grant=0, fifo_write_data=req_data slice 0. Reset mid-packet abandons the packet; no FIFO write issues in the reset cycle.
- Latency: req_valid rising in IDLE → first fifo_write_req next cycle (one arbitration bubble per packet).
- Throughput inside a packet: one beat per cycle while owner valid and !fifo_full.
- fifo_full gates same-cycle: a beat presented while fifo_full=1 is neither written nor acknowledged; it is written in the first cycle fifo_full=0.
- Back-to-back packets: last beat at cycle t → IDLE at t+1 (arbitration) → next packet's first write at t+2.
- Wrap-around: rr_ptr = NUM_REQ-1 → owner+1 wraps to 0; beat_cnt never exceeds MAX_BEATS.
- Single-beat packet (valid & last on first beat): BUSY lasts exactly one cycle when not full.

## Test plan
- Reset/idle: rst pulsed mid-packet with req_valid=4'b0010 → same cycle grant=0, req_ready=0, fifo_write_req=0; after release, arbitration restarts from rr_ptr=0, grant=4'b0010 one cycle later.
- Round robin: all four producers send 2-beat packets continuously → FIFO receives packets in order 0,1,2,3,0,… with no interleaving; each packet preceded by exactly one idle cycle.
- Backpressure: producer 2 sends 3 beats 0xA1,0xA2,0xA3(last); fifo_full=1 for 4 cycles after first beat → FIFO sees exactly A1,A2,A3 once each, req_ready[2]=0 during full, grant stays 4'b0100.
- Overrun: MAX_BEATS=16, producer 1 sends 20 beats without last while producer 3 valid → after beat 16 err_overrun pulses once, grant moves to 3, producer 1's beats 17–20 written only after producer 3's packet.
- Owner stall: producer 0 granted, drops req_valid for 5 cycles mid-packet while producer 1 valid → grant stays 4'b0001, no writes, producer 1 blocked until producer 0's last beat.
- Wrap: rr_ptr=3, only producers 3 and 0 valid → grant order 3 then 0, then rr_ptr=1.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Packet-level round-robin arbiter in front of a FIFO write port.
// A grant is held for a whole packet, or is force-released after MAX_BEATS beats.
module fifo_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write_req,
    output logic [WIDTH-1:0]           fifo_write_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       err_overrun
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
    logic            err_nxt;

    logic [OW-1:0]   winner;
    logic [OW-1:0]   scan;
    logic            any_valid;
    logic [OW-1:0]   owner_inc;
    logic [NUM_REQ-1:0] owner_onehot;
    logic            owner_valid;
    logic            owner_last;
    logic            accept;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        winner    = rr_ptr;
        any_valid = 1'b0;
        scan      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = OW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && req_valid[scan]) begin
                any_valid = 1'b1;
                winner    = scan;
            end
        end
    end

    always_comb begin
        owner_valid     = 1'b0;
        owner_last      = 1'b0;
        owner_onehot    = '0;
        fifo_write_data = req_data[WIDTH-1:0];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                owner_valid     = req_valid[i];
                owner_last      = req_last[i];
                owner_onehot[i] = 1'b1;
                fifo_write_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rr_ptr_nxt     = rr_ptr;
        beat_cnt_nxt   = beat_cnt;
        err_nxt        = 1'b0;
        req_ready      = '0;
        fifo_write_req = 1'b0;
        grant          = '0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt    = BUSY;
                    owner_nxt    = winner;
                    beat_cnt_nxt = '0;
                end
            end
            BUSY: begin
                grant          = owner_onehot;
                req_ready      = fifo_full ? '0 : owner_onehot;
                accept         = owner_valid && !fifo_full;
                fifo_write_req = accept;
                if (accept) begin
                    beat_cnt_nxt = beat_cnt + BW'(1);
                    // A last beat wins over the limit, so a packet of exactly MAX_BEATS is not an overrun.
                    if (owner_last || beat_cnt == BW'(MAX_BEATS - 1)) begin
                        state_nxt    = IDLE;
                        rr_ptr_nxt   = owner_inc;
                        beat_cnt_nxt = '0;
                        err_nxt      = !owner_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            beat_cnt    <= beat_cnt_nxt;
            err_overrun <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed packets per producer,
// expected FIFO writes queued up front and checked by an independent monitor.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_write_req;
    logic [7:0]  fifo_write_data;
    logic [3:0]  grant;
    logic        err_overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int wr_cyc [128];
    int err_cnt  = 0;
    int err_cyc  = 0;

    logic [8:0]  mem [4][64];
    int          head [4] = '{0, 0, 0, 0};
    int          tail [4] = '{0, 0, 0, 0};
    logic [3:0]  fire_q = '0;
    logic [3:0]  mask = '0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] g;
    } exp_t;
    exp_t sb [$];

    fifo_write_arbiter #(
        .WIDTH(8),
        .NUM_REQ(4),
        .MAX_BEATS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_write_req(fifo_write_req),
        .fifo_write_data(fifo_write_data),
        .grant(grant),
        .err_overrun(err_overrun)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(int p, logic [7:0] d, logic l);
        mem[p][tail[p]] = {l, d};
        tail[p]++;
    endtask

    task automatic expect_w(int p, logic [7:0] d);
        exp_t e;
        e.d = d;
        e.g = 4'(1 << p);
        sb.push_back(e);
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int i = 0; i < 4; i++) if (head[i] != tail[i]) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(int budget);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            #3;
            n++;
            done = (sb.size() == 0) && all_empty() && (grant == 4'b0000);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
    endtask

    task automatic wait_write(int target, int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_write_seen", 32'(wr_cnt >= target), 32'd1);
    endtask

    // Producer model: pop accepted beats after the edge, then present the next head.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = 32'hD3D2D1D0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (fire_q[i]) head[i]++;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (head[i] < tail[i]) begin
                    req_valid[i]         = !mask[i];
                    req_last[i]          = mem[i][head[i]][8];
                    req_data[i*8 +: 8]   = mem[i][head[i]][7:0];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_last[i]          = 1'b0;
                    req_data[i*8 +: 8]   = 8'hD0 + 8'(i);
                end
            end
        end
    end

    // Monitor: every FIFO write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            fire_q = req_valid & req_ready;
            if (err_overrun) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (fifo_write_req) begin
                if (wr_cnt < 128) wr_cyc[wr_cnt] = cyc;
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none", fifo_write_data);
                end else begin
                    e = sb.pop_front();
                    check("write_data", 32'(fifo_write_data), 32'(e.d));
                    check("write_grant", 32'(grant), 32'(e.g));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        int e0;
        fifo_full = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_write", 32'(fifo_write_req), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
        check("rst_data", 32'(fifo_write_data), 32'hD0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin: two 2-beat packets per producer, order 0,1,2,3,0,1,2,3.
        base = wr_cnt;
        for (int p = 0; p < 4; p++) begin
            push(p, 8'(p*16 + 0), 1'b0);
            push(p, 8'(p*16 + 1), 1'b1);
            push(p, 8'(p*16 + 2), 1'b0);
            push(p, 8'(p*16 + 3), 1'b1);
        end
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++)
                for (int b = 0; b < 2; b++)
                    expect_w(p, 8'(p*16 + k*2 + b));
        wait_idle(200);
        check("rr_span_cycles", 32'(wr_cyc[base+15] - wr_cyc[base]), 32'd22);

        // Backpressure on producer 2.
        base = wr_cnt;
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        expect_w(2, 8'hA1);
        expect_w(2, 8'hA2);
        expect_w(2, 8'hA3);
        wait_write(base + 1, 20);
        fifo_full = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("full_ready", 32'(req_ready), 32'd0);
            check("full_grant", 32'(grant), 32'b0100);
            check("full_write", 32'(fifo_write_req), 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        wait_idle(50);

        // Reset with producer 1 granted; rr_ptr is 3 beforehand, 0 afterwards.
        fifo_full = 1'b1;
        push(1, 8'h91, 1'b0);
        push(1, 8'h92, 1'b0);
        push(1, 8'h93, 1'b0);
        push(1, 8'h94, 1'b1);
        begin
            int n = 0;
            while (grant != 4'b0010 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("pre_reset_grant", 32'(grant), 32'b0010);
        push(3, 8'h3A, 1'b0);
        push(3, 8'h3B, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_write", 32'(fifo_write_req), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        fifo_full = 1'b0;
        expect_w(1, 8'h91);
        expect_w(1, 8'h92);
        expect_w(1, 8'h93);
        expect_w(1, 8'h94);
        expect_w(3, 8'h3A);
        expect_w(3, 8'h3B);
        @(negedge clk);
        check("post_rst_bubble", 32'(grant), 32'd0);
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'b0010);
        wait_idle(50);

        // Overrun: producer 1 streams 20 beats, producer 3 slips in after beat 16.
        base = wr_cnt;
        e0   = err_cnt;
        for (int k = 1; k <= 20; k++) push(1, 8'(64 + k), k == 20);
        push(3, 8'hC1, 1'b0);
        push(3, 8'hC2, 1'b1);
        for (int k = 1; k <= 16; k++) expect_w(1, 8'(64 + k));
        expect_w(3, 8'hC1);
        expect_w(3, 8'hC2);
        for (int k = 17; k <= 20; k++) expect_w(1, 8'(64 + k));
        wait_idle(300);
        check("overrun_pulses", 32'(err_cnt - e0), 32'd1);
        check("overrun_timing", 32'(err_cyc - wr_cyc[base+15]), 32'd1);

        // Owner stall: producer 0 goes quiet mid-packet, producer 1 must wait.
        base = wr_cnt;
        push(0, 8'h71, 1'b0);
        push(0, 8'h72, 1'b0);
        push(0, 8'h73, 1'b1);
        push(1, 8'h81, 1'b1);
        expect_w(0, 8'h71);
        expect_w(0, 8'h72);
        expect_w(0, 8'h73);
        expect_w(1, 8'h81);
        wait_write(base + 1, 20);
        mask[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_grant", 32'(grant), 32'b0001);
            check("stall_write", 32'(fifo_write_req), 32'd0);
            check("stall_ready1", 32'(req_ready[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        mask[0] = 1'b0;
        wait_idle(50);

        // Wrap: bring rr_ptr to 3, then 3 beats 0, then rr_ptr=1 favours 1.
        push(2, 8'hE1, 1'b1);
        expect_w(2, 8'hE1);
        wait_idle(30);
        push(3, 8'hF1, 1'b0);
        push(3, 8'hF2, 1'b1);
        push(0, 8'h0A, 1'b1);
        expect_w(3, 8'hF1);
        expect_w(3, 8'hF2);
        expect_w(0, 8'h0A);
        wait_idle(30);
        push(0, 8'h0B, 1'b1);
        push(1, 8'h1B, 1'b1);
        push(3, 8'h3C, 1'b1);
        expect_w(1, 8'h1B);
        expect_w(3, 8'h3C);
        expect_w(0, 8'h0B);
        wait_idle(40);

        check("total_overruns", 32'(err_cnt), 32'd1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
